// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, parity modes and parity check for the PS/2 frame receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // data is zero-extended by the caller; padding zeros do not change the XOR
  function automatic logic parity_ok(input logic [15:0] data, input logic p, input int mode);
    logic x;
    x = (^data) ^ p;
    case (mode)
      PARITY_ODD:  return x;
      PARITY_EVEN: return !x;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// rtl/ps2_frame_receiver_if.sv - valid/ready word output of the frame receiver
interface ps2_frame_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ps2_rx_timeout.sv
// rtl/ps2_rx_timeout.sv - saturating mid-frame inactivity counter
module ps2_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // fires in the cycle whose edge would bring the count to TIMEOUT_CYCLES; a strobe wins
  assign expire = enable && !clear && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - start/data/parity/stop frame receiver with error reporting
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_MODE    = PARITY_ODD,
  parameter int STOP_BITS      = 1,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 data_in,
  ps2_frame_receiver_if.master rx_if,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 timeout_err,
  output logic                 overrun
);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  state_e                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [1:0]            stop_cnt_q, stop_cnt_d;
  logic                  par_q, par_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  framing_err_q, framing_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  overrun_q, overrun_d;
  logic                  expire;
  logic                  accept;
  logic                  deliver;
  logic [15:0]           data_ext;

  ps2_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (sample_en),
    .enable (state_q != S_IDLE),
    .expire (expire)
  );

  assign accept = rx_valid_q && rx_if.rx_ready;

  always_comb begin
    data_ext                 = '0;
    data_ext[DATA_WIDTH-1:0] = shift_q;
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    stop_cnt_d    = stop_cnt_q;
    par_d         = par_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    parity_err_d  = 1'b0;
    framing_err_d = 1'b0;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    deliver       = 1'b0;

    if (accept) begin
      rx_valid_d = 1'b0;
    end

    if (expire) begin
      state_d       = S_IDLE;
      timeout_err_d = 1'b1;
    end else if (sample_en) begin
      case (state_q)
        S_IDLE: begin
          if (!data_in) begin
            state_d    = S_DATA;
            bit_cnt_d  = '0;
            stop_cnt_d = '0;
            shift_d    = '0;
          end
        end
        S_DATA: begin
          // LSB arrives first and ends up at bit 0 after DATA_WIDTH shifts
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = data_in;
          bit_cnt_d               = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            state_d = (PARITY_MODE == PARITY_NONE) ? S_STOP : S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = data_in;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (!data_in) begin
            framing_err_d = 1'b1;
            state_d       = S_IDLE;
          end else if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            if (!parity_ok(data_ext, par_q, PARITY_MODE)) begin
              parity_err_d = 1'b1;
            end else begin
              deliver = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // a same-cycle accept frees the output register for the new word
    if (deliver) begin
      if (!rx_valid_q || accept) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      stop_cnt_q    <= '0;
      par_q         <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      stop_cnt_q    <= stop_cnt_d;
      par_q         <= par_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign busy           = (state_q != S_IDLE);
  assign parity_err     = parity_err_q;
  assign framing_err    = framing_err_q;
  assign timeout_err    = timeout_err_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb/tb_ps2_frame_receiver.sv - odd/even 8-bit and 9-bit/2-stop receivers against a frame-level model
module tb_ps2_frame_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       se8, din8, se9, din9;
  logic [2:0] rdy;
  logic [2:0] busy, perr, ferr, terr, ovr;

  ps2_frame_receiver_if #(.DATA_WIDTH(8)) if_odd ();
  ps2_frame_receiver_if #(.DATA_WIDTH(8)) if_even ();
  ps2_frame_receiver_if #(.DATA_WIDTH(9)) if9 ();

  assign if_odd.rx_ready  = rdy[0];
  assign if_even.rx_ready = rdy[1];
  assign if9.rx_ready     = rdy[2];

  ps2_frame_receiver #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .TIMEOUT_CYCLES(16)) dut_odd (
    .clk(clk), .reset(reset), .sample_en(se8), .data_in(din8), .rx_if(if_odd),
    .busy(busy[0]), .parity_err(perr[0]), .framing_err(ferr[0]), .timeout_err(terr[0]), .overrun(ovr[0]));

  ps2_frame_receiver #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1), .TIMEOUT_CYCLES(16)) dut_even (
    .clk(clk), .reset(reset), .sample_en(se8), .data_in(din8), .rx_if(if_even),
    .busy(busy[1]), .parity_err(perr[1]), .framing_err(ferr[1]), .timeout_err(terr[1]), .overrun(ovr[1]));

  ps2_frame_receiver #(.DATA_WIDTH(9), .PARITY_MODE(0), .STOP_BITS(2), .TIMEOUT_CYCLES(64)) dut_nine (
    .clk(clk), .reset(reset), .sample_en(se9), .data_in(din9), .rx_if(if9),
    .busy(busy[2]), .parity_err(perr[2]), .framing_err(ferr[2]), .timeout_err(terr[2]), .overrun(ovr[2]));

  int n_assert;
  int n_fail;

  // frame-level model: held output word per receiver plus expected pulses for the next edge
  logic [2:0]  mv;
  logic [15:0] md [3];
  logic [15:0] dv [3];
  logic [15:0] p_dv [3];
  logic [2:0]  dlv, e_perr, e_ferr, e_terr, e_ovr;
  logic [2:0]  p_dlv, p_perr, p_ferr;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [2:0]  ov;
    logic [15:0] od [3];
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mv[i] = 1'b0;
        md[i] = '0;
      end else if (dlv[i]) begin
        if (mv[i] && !rdy[i]) e_ovr[i] = 1'b1;
        else begin
          md[i] = dv[i];
          mv[i] = 1'b1;
        end
      end else if (mv[i] && rdy[i]) begin
        mv[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    ov    = {if9.rx_valid, if_even.rx_valid, if_odd.rx_valid};
    od[0] = {8'h00, if_odd.rx_data};
    od[1] = {8'h00, if_even.rx_data};
    od[2] = {7'h00, if9.rx_data};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rx_valid%0d", i), 16'(ov[i]), 16'(mv[i]));
      check($sformatf("rx_data%0d", i), od[i], md[i]);
      check($sformatf("parity_err%0d", i), 16'(perr[i]), 16'(e_perr[i]));
      check($sformatf("framing_err%0d", i), 16'(ferr[i]), 16'(e_ferr[i]));
      check($sformatf("timeout_err%0d", i), 16'(terr[i]), 16'(e_terr[i]));
      check($sformatf("overrun%0d", i), 16'(ovr[i]), 16'(e_ovr[i]));
    end
    dlv = '0; e_perr = '0; e_ferr = '0; e_terr = '0; e_ovr = '0;
  endtask

  task automatic strobe(input int port, input logic b, input int gap, input logic fin);
    for (int g = 0; g < gap; g++) begin
      if (port == 0) din8 = 1'($urandom_range(0, 1));
      else           din9 = 1'($urandom_range(0, 1));
      tick();
    end
    if (port == 0) begin se8 = 1'b1; din8 = b; end
    else           begin se9 = 1'b1; din9 = b; end
    if (fin) begin
      dlv = p_dlv; e_perr = p_perr; e_ferr = p_ferr;
      for (int i = 0; i < 3; i++) dv[i] = p_dv[i];
      p_dlv = '0; p_perr = '0; p_ferr = '0;
    end
    tick();
    se8 = 1'b0;
    se9 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] data, input logic p, input logic stop, input int long_idx);
    logic [10:0] bits;
    logic        good;
    bits = {stop, p, data, 1'b0};
    for (int i = 0; i < 2; i++) begin
      good = ((($countones(data) + int'(p)) % 2) == ((i == 0) ? 1 : 0));
      if (!stop)      p_ferr[i] = 1'b1;
      else if (!good) p_perr[i] = 1'b1;
      else begin
        p_dlv[i] = 1'b1;
        p_dv[i]  = {8'h00, data};
      end
    end
    for (int k = 0; k < 11; k++)
      strobe(0, bits[k], (k == long_idx) ? 15 : int'($urandom_range(0, 4)), k == 10);
  endtask

  task automatic send9(input logic [8:0] data, input logic s1, input logic s2);
    logic [11:0] bits;
    int          n;
    bits = {s2, s1, data, 1'b0};
    n    = s1 ? 12 : 11;
    if (!s1 || !s2) p_ferr[2] = 1'b1;
    else begin
      p_dlv[2] = 1'b1;
      p_dv[2]  = {7'h00, data};
    end
    for (int k = 0; k < n; k++)
      strobe(1, bits[k], int'($urandom_range(0, 4)), k == n - 1);
  endtask

  task automatic partial_frame();
    strobe(0, 1'b0, 2, 1'b0);
    for (int k = 0; k < 3; k++) strobe(0, 1'($urandom_range(0, 1)), 2, 1'b0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    reset = 1'b1; se8 = 1'b0; din8 = 1'b1; se9 = 1'b0; din9 = 1'b1; rdy = 3'b111;
    mv = '0; dlv = '0; e_perr = '0; e_ferr = '0; e_terr = '0; e_ovr = '0;
    p_dlv = '0; p_perr = '0; p_ferr = '0;
    for (int i = 0; i < 3; i++) begin md[i] = '0; dv[i] = '0; p_dv[i] = '0; end

    tick();
    tick();
    check("reset_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    tick();

    // 1: default odd-parity frame
    send8(8'h1C, 1'b0, 1'b1, 99);
    check("t1_data", {8'h00, if_odd.rx_data}, 16'h001C);
    check("t1_busy", 16'(busy[0]), 16'd0);

    // 2: bad parity, then a good frame
    send8(8'h1C, 1'b1, 1'b1, 99);
    send8(8'h32, 1'b0, 1'b1, 99);
    check("t2_data", {8'h00, if_odd.rx_data}, 16'h0032);

    // 3: stop bit low, then idle line strobed high
    send8(8'h1C, 1'b0, 1'b0, 99);
    check("t3_busy", 16'(busy[1:0]), 16'd0);
    for (int k = 0; k < 4; k++) begin
      strobe(0, 1'b1, 1, 1'b0);
      check("t3_idle_busy", 16'(busy[1:0]), 16'd0);
    end

    // 4: consumer stalled across two good frames
    rdy = 3'b100;
    send8(8'h1C, 1'b0, 1'b1, 99);
    send8(8'h32, 1'b0, 1'b1, 99);
    check("t4_hold", {8'h00, if_odd.rx_data}, 16'h001C);
    rdy = 3'b111;
    tick();
    check("t4_cleared", 16'(if_odd.rx_valid), 16'd0);

    // strobe arriving in the would-be expiry cycle keeps the frame alive
    send8(8'hA7, 1'b0, 1'b1, 5);

    // 5: timeout 16 cycles after the last strobe
    partial_frame();
    check("t5_busy_mid", 16'(busy[1:0]), 16'd3);
    repeat (15) tick();
    check("t5_busy_before", 16'(busy[1:0]), 16'd3);
    e_terr = 3'b011;
    tick();
    check("t5_busy_after", 16'(busy[1:0]), 16'd0);
    tick();

    // reset mid-frame with a word pending
    rdy = 3'b100;
    send8(8'h1C, 1'b0, 1'b1, 99);
    partial_frame();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_reset_busy", 16'(busy), 16'd0);
    rdy = 3'b111;
    tick();

    // 6: nine data bits, no parity, two stop bits
    send9(9'h1A5, 1'b1, 1'b1);
    check("t6_data", {7'h00, if9.rx_data}, 16'h01A5);
    send9(9'h0F3, 1'b1, 1'b0);
    send9(9'h055, 1'b0, 1'b1);
    check("t6_busy", 16'(busy[2]), 16'd0);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      rdy[1:0] = 2'($urandom_range(0, 3));
      send8(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), int'($urandom_range(1, 30)));
    end
    for (int f = 0; f < 10; f++) begin
      rdy[2] = ($urandom_range(0, 3) != 0);
      send9(9'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0));
    end
    rdy = 3'b111;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
